pbit_sweep_scheduler: RTL and testbench

Sequencer for the p-bit array. It issues one-hot update enables to the P+1 p-bits in fixed index order, each enable followed by a programmable settle gap so the multiply-accumulate input network settles on the updated state. After every full sweep it snapshots the p-bit outputs into a sample register with a valid/ready handshake, and it runs a requested number of sweeps. It replaces free-running hard-coded enable sequencing in the p-bit top levels.

---
 rtl/pbit_sweep_scheduler.sv | 255 +++++++++++++++++++++++++
 tb/tb_pbit_sweep_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_sweep_scheduler.sv
//------------------------------------------------------------------------------
// Module   : pbit_sweep_scheduler
// Purpose  : Sequencer for the p-bit array. It walks a one-hot update enable
//            across the P+1 p-bits in index order. Each enable slot is
//            followed by a settle gap. After every full sweep it snapshots
//            pbit_val_i into a sample register, which has a valid/ready
//            handshake. It runs a requested number of sample-producing sweeps.
// Revision : 1.0 - initial release
//
// Optional feature macro: PBIT_SCHED_BURNIN_EN
//   When defined, each run first executes BURNIN warm-up sweeps. These sweeps
//   produce no sample, do not count and never stall.
//
// Ports
//   CLK            in   clock, all state on rising edge
//   RST            in   synchronous active-high reset
//   start_i        in   begin a run (sampled only while idle)
//   stop_i         in   abort the run (any non-idle state)
//   num_sweeps_i   in   sample-producing sweeps to run, latched on start
//   pbit_val_i     in   current p-bit outputs
//   en_o           out  registered one-hot (or zero) update enables
//   busy_o         out  high whenever not idle
//   sample_o       out  pbit_val_i snapshot taken at end of sweep
//   sample_valid_o out  sample_o holds unconsumed data
//   sample_ready_i in   consumer accepts sample on valid && ready
//   sweep_cnt_o    out  sample-producing sweeps completed in this run
//   done_o         out  one-cycle pulse at normal run completion
//------------------------------------------------------------------------------
`default_nettype none

module pbit_sweep_scheduler #(
   parameter int P          = 4,
   parameter int EN_CYCLES  = 1,
   parameter int GAP_CYCLES = 2,
   parameter int SWEEP_W    = 16
`ifdef PBIT_SCHED_BURNIN_EN
   ,
   parameter int BURNIN     = 8
`endif
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [SWEEP_W-1:0] num_sweeps_i,
   input  logic [P:0]         pbit_val_i,
   output logic [P:0]         en_o,
   output logic               busy_o,
   output logic [P:0]         sample_o,
   output logic               sample_valid_o,
   input  logic               sample_ready_i,
   output logic [SWEEP_W-1:0] sweep_cnt_o,
   output logic               done_o
);

   localparam int IW   = (P > 0) ? $clog2(P + 1) : 1;
   localparam int CMAX = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST = IW'(P);
   localparam logic [P:0]    EN_ONE   = {{P{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ENABLE = 2'd1,
      S_GAP    = 2'd2,
      S_STALL  = 2'd3
   } state_t;

   state_t             state_q,  state_d;
   logic [IW-1:0]      idx_q,    idx_d;
   logic [CW-1:0]      cnt_q,    cnt_d;
   logic [SWEEP_W-1:0] num_q,    num_d;
   logic [SWEEP_W-1:0] swc_q,    swc_d;
   logic [P:0]         sample_q, sample_d;
   logic               valid_q,  valid_d;
   logic               done_q,   done_d;
   logic [P:0]         en_q,     en_d;

   logic               slot_end;
   logic               sweep_end;
   logic               in_burnin;
   logic [SWEEP_W-1:0] swc_inc;

   assign swc_inc = swc_q + SWEEP_W'(1);

`ifdef PBIT_SCHED_BURNIN_EN
   localparam int BW = (BURNIN > 0) ? $clog2(BURNIN + 1) : 1;

   logic [BW-1:0] burn_q, burn_d;

   assign in_burnin = (burn_q < BW'(BURNIN));

   always_ff @(posedge CLK) begin
      if (RST) begin
         burn_q <= '0;
      end else begin
         burn_q <= burn_d;
      end
   end
`else
   assign in_burnin = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         num_q    <= '0;
         swc_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         en_q     <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         num_q    <= num_d;
         swc_q    <= swc_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         en_q     <= en_d;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      num_d     = num_q;
      swc_d     = swc_q;
      sample_d  = sample_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      slot_end  = 1'b0;
      sweep_end = 1'b0;
`ifdef PBIT_SCHED_BURNIN_EN
      burn_d    = burn_q;
`endif

      // Consumer handshake. A capture on the same edge overrides this below.
      if (valid_q && sample_ready_i) begin
         valid_d = 1'b0;
      end

      if ((state_q != S_IDLE) && stop_i) begin
         // Abort wins over everything. The sample data and the count are kept.
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  num_d = num_sweeps_i;
                  swc_d = '0;
                  idx_d = '0;
                  cnt_d = '0;
`ifdef PBIT_SCHED_BURNIN_EN
                  burn_d = '0;
`endif
                  if (num_sweeps_i == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = S_ENABLE;
                  end
               end
            end
            S_ENABLE: begin
               if (cnt_q == EN_LAST) begin
                  cnt_d = '0;
                  if (GAP_CYCLES == 0) begin
                     slot_end = 1'b1;
                  end else begin
                     state_d = S_GAP;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d    = '0;
                  slot_end = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_STALL: begin
               sweep_end = sample_ready_i;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         if (slot_end) begin
            if (idx_q != IDX_LAST) begin
               idx_d   = idx_q + IW'(1);
               state_d = S_ENABLE;
            end else begin
               sweep_end = 1'b1;
            end
         end

         if (sweep_end) begin
            if (in_burnin) begin
`ifdef PBIT_SCHED_BURNIN_EN
               burn_d  = burn_q + BW'(1);
`endif
               idx_d   = '0;
               state_d = S_ENABLE;
            end else if (valid_q && !sample_ready_i) begin
               // The previous sample is still unconsumed. Hold off the capture.
               state_d = S_STALL;
            end else begin
               sample_d = pbit_val_i;
               valid_d  = 1'b1;
               swc_d    = swc_inc;
               idx_d    = '0;
               if (swc_inc == num_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ENABLE;
               end
            end
         end
      end

      // The enables are registered from the next state, so that they line up
      // with the state they belong to.
      en_d = (state_d == S_ENABLE) ? (EN_ONE << idx_d) : '0;
   end

   assign en_o           = en_q;
   assign busy_o         = (state_q != S_IDLE);
   assign sample_o       = sample_q;
   assign sample_valid_o = valid_q;
   assign sweep_cnt_o    = swc_q;
   assign done_o         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pbit_sweep_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_pbit_sweep_scheduler
// Purpose  : Self-checking bench for pbit_sweep_scheduler. It uses
//            P=4, EN_CYCLES=1 and GAP_CYCLES=2, which gives 15-cycle sweeps.
//            Expected samples are queued when a capture edge is predicted.
//            They are popped when the valid/ready handshake fires.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pbit_sweep_scheduler;

   localparam int P = 4;
   localparam int SW = 16;
   localparam int SWEEP = 15;
`ifdef PBIT_SCHED_BURNIN_EN
   localparam int B = 2;
`else
   localparam int B = 0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start_i = 1'b0;
   logic          stop_i = 1'b0;
   logic [SW-1:0] num_sweeps_i = '0;
   logic [P:0]    pbit_val_i = '0;
   logic [P:0]    en_o;
   logic          busy_o;
   logic [P:0]    sample_o;
   logic          sample_valid_o;
   logic          sample_ready_i = 1'b0;
   logic [SW-1:0] sweep_cnt_o;
   logic          done_o;

   int n_checks = 0;
   int n_pass   = 0;
   logic [P:0] sb[$];
   logic [P:0] pv_edge;

   always #5 CLK = ~CLK;

   pbit_sweep_scheduler #(
      .P(4), .EN_CYCLES(1), .GAP_CYCLES(2), .SWEEP_W(SW)
`ifdef PBIT_SCHED_BURNIN_EN
      , .BURNIN(2)
`endif
   ) dut (
      .CLK(CLK), .RST(RST), .start_i(start_i), .stop_i(stop_i),
      .num_sweeps_i(num_sweeps_i), .pbit_val_i(pbit_val_i), .en_o(en_o),
      .busy_o(busy_o), .sample_o(sample_o), .sample_valid_o(sample_valid_o),
      .sample_ready_i(sample_ready_i), .sweep_cnt_o(sweep_cnt_o), .done_o(done_o)
   );

   // Advance one clock edge. pv_edge remembers the p-bit value that this edge
   // sampled. A fresh random value is then driven.
   task automatic tick();
      pv_edge = pbit_val_i;
      @(posedge CLK);
      #1;
      pbit_val_i = (P+1)'($urandom);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({en_o, busy_o, sample_o, sample_valid_o, sweep_cnt_o, done_o} !== '0)
         $display("FAIL reset_outputs: got en=%b busy=%b sample=%b valid=%b cnt=%0d done=%b, expected all zero",
                  en_o, busy_o, sample_o, sample_valid_o, sweep_cnt_o, done_o);
      else n_pass++;
      RST = 1'b0;
      tick();
      n_checks++;
      if ({en_o, busy_o, done_o} !== '0)
         $display("FAIL reset_idle: got en=%b busy=%b done=%b, expected 0", en_o, busy_o, done_o);
      else n_pass++;
   endtask

   // Full run with sample_ready_i held high. Captures are predicted every SWEEP
   // cycles after any burn-in.
   task automatic test_basic(input int num);
      int total;
      int done_seen;
      int j;
      logic [P:0] exp_en;
      logic [P:0] exp_s;
      total = (B + num) * SWEEP;
      done_seen = 0;
      sample_ready_i = 1'b1;
      num_sweeps_i = SW'(num);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int k = 0; k <= total; k++) begin
         if (k > 0) tick();
         if (k >= SWEEP * (B + 1) && (k % SWEEP) == 0) sb.push_back(pv_edge);
         if (k < total) begin
            j = k % SWEEP;
            exp_en = ((j % 3) == 0) ? (EN_ONE() << (j / 3)) : '0;
            n_checks++;
            if ({busy_o, en_o} !== {1'b1, exp_en})
               $display("FAIL basic_en k=%0d: got busy=%b en=%b, expected busy=1 en=%b", k, busy_o, en_o, exp_en);
            else n_pass++;
         end
         if (k == SWEEP * (B + 1) - 1) begin
            n_checks++;
            if (sample_valid_o !== 1'b0)
               $display("FAIL basic_no_early_valid: got %b expected 0", sample_valid_o);
            else n_pass++;
         end
         if (done_o === 1'b1) done_seen++;
         if (sample_valid_o && sample_ready_i) begin
            n_checks++;
            if (sb.size() == 0) begin
               $display("FAIL basic_hs k=%0d: got unexpected sample %b, expected none", k, sample_o);
            end else begin
               exp_s = sb.pop_front();
               if (sample_o !== exp_s)
                  $display("FAIL basic_hs k=%0d: got sample %b expected %b", k, sample_o, exp_s);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if ({done_o, busy_o, en_o, sweep_cnt_o} !== {1'b1, 1'b0, 5'b0, SW'(num)})
         $display("FAIL basic_end: got done=%b busy=%b en=%b cnt=%0d, expected done=1 busy=0 en=0 cnt=%0d",
                  done_o, busy_o, en_o, sweep_cnt_o, num);
      else n_pass++;
      tick();
      n_checks++;
      if ({done_o, sample_valid_o, done_seen, sb.size()} !== {1'b0, 1'b0, 32'd1, 32'd0})
         $display("FAIL basic_after: got done=%b valid=%b pulses=%0d queued=%0d, expected 0 0 1 0",
                  done_o, sample_valid_o, done_seen, sb.size());
      else n_pass++;
   endtask

   function automatic logic [P:0] EN_ONE();
      return {{P{1'b0}}, 1'b1};
   endfunction

   task automatic test_stall();
      logic [P:0] exp_s;
      sample_ready_i = 1'b0;
      num_sweeps_i = SW'(3);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (SWEEP * (B + 1)) tick();
      sb.push_back(pv_edge);
      n_checks++;
      if ({sample_valid_o, sweep_cnt_o} !== {1'b1, SW'(1)})
         $display("FAIL stall_cap1: got valid=%b cnt=%0d expected 1 1", sample_valid_o, sweep_cnt_o);
      else n_pass++;
      repeat (SWEEP + 4) tick();
      n_checks++;
      if ({en_o, busy_o, sweep_cnt_o, sample_valid_o, sample_o} !== {5'b0, 1'b1, SW'(1), 1'b1, sb[0]})
         $display("FAIL stall_hold: got en=%b busy=%b cnt=%0d valid=%b sample=%b, expected 0 1 1 1 %b",
                  en_o, busy_o, sweep_cnt_o, sample_valid_o, sample_o, sb[0]);
      else n_pass++;
      sample_ready_i = 1'b1;
      n_checks++;
      if (!sample_valid_o || sb.size() == 0) begin
         $display("FAIL stall_hs1: got valid=%b expected a pending sample", sample_valid_o);
      end else begin
         exp_s = sb.pop_front();
         if (sample_o !== exp_s) $display("FAIL stall_hs1: got %b expected %b", sample_o, exp_s);
         else n_pass++;
      end
      tick();
      sb.push_back(pv_edge);
      sample_ready_i = 1'b0;
      n_checks++;
      if ({sample_valid_o, sweep_cnt_o, en_o} !== {1'b1, SW'(2), 5'b00001})
         $display("FAIL stall_release: got valid=%b cnt=%0d en=%b expected 1 2 00001",
                  sample_valid_o, sweep_cnt_o, en_o);
      else n_pass++;
      repeat (SWEEP) tick();
      n_checks++;
      if ({en_o, busy_o, done_o, sweep_cnt_o} !== {5'b0, 1'b1, 1'b0, SW'(2)})
         $display("FAIL stall_second: got en=%b busy=%b done=%b cnt=%0d expected 0 1 0 2",
                  en_o, busy_o, done_o, sweep_cnt_o);
      else n_pass++;
      sample_ready_i = 1'b1;
      n_checks++;
      if (!sample_valid_o || sb.size() == 0) begin
         $display("FAIL stall_hs2: got valid=%b expected a pending sample", sample_valid_o);
      end else begin
         exp_s = sb.pop_front();
         if (sample_o !== exp_s) $display("FAIL stall_hs2: got %b expected %b", sample_o, exp_s);
         else n_pass++;
      end
      tick();
      sb.push_back(pv_edge);
      n_checks++;
      if ({done_o, busy_o, sweep_cnt_o, sample_valid_o} !== {1'b1, 1'b0, SW'(3), 1'b1})
         $display("FAIL stall_done: got done=%b busy=%b cnt=%0d valid=%b expected 1 0 3 1",
                  done_o, busy_o, sweep_cnt_o, sample_valid_o);
      else n_pass++;
      n_checks++;
      if (!sample_valid_o || sb.size() == 0) begin
         $display("FAIL stall_hs3: got valid=%b expected a pending sample", sample_valid_o);
      end else begin
         exp_s = sb.pop_front();
         if (sample_o !== exp_s) $display("FAIL stall_hs3: got %b expected %b", sample_o, exp_s);
         else n_pass++;
      end
      tick();
      n_checks++;
      if ({sample_valid_o, done_o, sb.size()} !== {1'b0, 1'b0, 32'd0})
         $display("FAIL stall_drain: got valid=%b done=%b queued=%0d expected 0 0 0",
                  sample_valid_o, done_o, sb.size());
      else n_pass++;
   endtask

   task automatic test_zero();
      sample_ready_i = 1'b0;
      num_sweeps_i = '0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      n_checks++;
      if ({done_o, busy_o, en_o, sweep_cnt_o} !== {1'b1, 1'b0, 5'b0, SW'(0)})
         $display("FAIL zero_done: got done=%b busy=%b en=%b cnt=%0d expected 1 0 0 0",
                  done_o, busy_o, en_o, sweep_cnt_o);
      else n_pass++;
      tick();
      n_checks++;
      if ({done_o, en_o, busy_o} !== '0)
         $display("FAIL zero_after: got done=%b en=%b busy=%b expected 0", done_o, en_o, busy_o);
      else n_pass++;
   endtask

   task automatic test_stop();
      logic [P:0] kept;
      logic [P:0] exp_s;
      sample_ready_i = 1'b0;
      num_sweeps_i = SW'(3);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (SWEEP * (B + 1)) tick();
      sb.push_back(pv_edge);
      kept = pv_edge;
      repeat (7) tick();
      n_checks++;
      if ({en_o, busy_o} !== {5'b0, 1'b1})
         $display("FAIL stop_in_gap: got en=%b busy=%b expected 0 1", en_o, busy_o);
      else n_pass++;
      stop_i = 1'b1;
      start_i = 1'b1;
      tick();
      stop_i = 1'b0;
      start_i = 1'b0;
      n_checks++;
      if ({en_o, busy_o, done_o, sample_o, sample_valid_o, sweep_cnt_o} !== {5'b0, 1'b0, 1'b0, kept, 1'b1, SW'(1)})
         $display("FAIL stop_abort: got en=%b busy=%b done=%b sample=%b valid=%b cnt=%0d expected 0 0 0 %b 1 1",
                  en_o, busy_o, done_o, sample_o, sample_valid_o, sweep_cnt_o, kept);
      else n_pass++;
      repeat (3) tick();
      n_checks++;
      if ({en_o, busy_o, done_o} !== '0)
         $display("FAIL stop_idle: got en=%b busy=%b done=%b expected 0", en_o, busy_o, done_o);
      else n_pass++;
      sample_ready_i = 1'b1;
      n_checks++;
      if (!sample_valid_o || sb.size() == 0) begin
         $display("FAIL stop_hs: got valid=%b expected a pending sample", sample_valid_o);
      end else begin
         exp_s = sb.pop_front();
         if (sample_o !== exp_s) $display("FAIL stop_hs: got %b expected %b", sample_o, exp_s);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (sample_valid_o !== 1'b0)
         $display("FAIL stop_drain: got valid=%b expected 0", sample_valid_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      sample_ready_i = 1'b0;
      num_sweeps_i = SW'(2);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (SWEEP * (B + 2)) tick();
      n_checks++;
      if ({en_o, busy_o, sample_valid_o} !== {5'b0, 1'b1, 1'b1})
         $display("FAIL rstmid_stall: got en=%b busy=%b valid=%b expected 0 1 1", en_o, busy_o, sample_valid_o);
      else n_pass++;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_checks++;
      if ({en_o, busy_o, sample_o, sample_valid_o, sweep_cnt_o, done_o} !== '0)
         $display("FAIL rstmid_outputs: got en=%b busy=%b sample=%b valid=%b cnt=%0d done=%b expected all zero",
                  en_o, busy_o, sample_o, sample_valid_o, sweep_cnt_o, done_o);
      else n_pass++;
      sb.delete();
      test_basic(1);
   endtask

   initial begin
      test_reset();
      test_basic(2);
      test_stall();
      test_zero();
      test_stop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
